// File: rtl/divider_module.sv
// Sequential BCD fixed-point divider (XXX.X / XXX.X -> XXX.X) between KPN channel FIFOs.
// Restoring binary division of 10*dividend by divisor, then double-dabble back to BCD.
module divider_module (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] entry_1,
    input  logic [15:0] entry_2,
    input  logic        empty_1,
    input  logic        empty_2,
    input  logic        full_out,
    output logic        rd,
    output logic        wr,
    output logic [15:0] output_1,
    output logic        overflow,
    output logic        div_zero,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CONVERT,
        S_DIVIDE,
        S_BCD,
        S_WRITE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] dvd_bcd;
    logic [15:0] dvs_bcd;
    logic [16:0] n_sh;
    logic [13:0] b_bin;
    logic [16:0] rem;
    logic [4:0]  cnt;
    logic [15:0] bcd;
    logic [13:0] bin_sh;

    function automatic logic [14:0] bcd_to_bin(input logic [15:0] d);
        return 15'(d[15:12]) * 15'd1000 + 15'(d[11:8]) * 15'd100
             + 15'(d[7:4]) * 15'd10 + 15'(d[3:0]);
    endfunction

    logic [14:0] dvd_bin;
    logic [14:0] dvs_bin;
    logic [16:0] n_init;
    logic [13:0] b_init;

    assign dvd_bin = bcd_to_bin(dvd_bcd);
    assign dvs_bin = bcd_to_bin(dvs_bcd);
    assign n_init  = 17'(dvd_bin) * 17'd10;
    assign b_init  = dvs_bin[13:0];

    // One restoring step: n_sh shifts the dividend out at the top and the quotient in at the bottom.
    logic [16:0] trial;
    logic        fits;
    logic [16:0] rem_next;
    logic [16:0] q_next;
    logic        q_too_big;

    assign trial     = {rem[15:0], n_sh[16]};
    assign fits      = trial >= {3'b000, b_bin};
    assign rem_next  = fits ? (trial - {3'b000, b_bin}) : trial;
    assign q_next    = {n_sh[15:0], fits};
    assign q_too_big = q_next > 17'd9999;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    logic [15:0] bcd_corr;
    logic [15:0] dabble_bcd;
    logic [13:0] dabble_bin;

    assign bcd_corr   = {add3(bcd[15:12]), add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
    assign dabble_bcd = {bcd_corr[14:0], bin_sh[13]};
    assign dabble_bin = {bin_sh[12:0], 1'b0};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (!empty_1 && !empty_2) state_next = S_READ;
            S_READ:    state_next = S_CONVERT;
            S_CONVERT: state_next = (b_init == 14'd0) ? S_WRITE : S_DIVIDE;
            S_DIVIDE:  if (cnt == 5'd0) state_next = q_too_big ? S_WRITE : S_BCD;
            S_BCD:     if (cnt == 5'd0) state_next = S_WRITE;
            S_WRITE:   if (!full_out) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // rd pops both input heads and wr pushes output_1; each is a single-cycle strobe that
    // fires only when the FIFO status allows it, and an asserted reset suppresses both.
    always_comb begin
        rd   = (state == S_READ) && !reset;
        wr   = (state == S_WRITE) && !full_out && !reset;
        busy = (state != S_IDLE) && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            output_1 <= 16'h0000;
            overflow <= 1'b0;
            div_zero <= 1'b0;
            dvd_bcd  <= 16'h0000;
            dvs_bcd  <= 16'h0000;
            n_sh     <= 17'd0;
            b_bin    <= 14'd0;
            rem      <= 17'd0;
            cnt      <= 5'd0;
            bcd      <= 16'h0000;
            bin_sh   <= 14'd0;
        end else begin
            case (state)
                S_READ: begin
                    dvd_bcd <= entry_1;
                    dvs_bcd <= entry_2;
                end
                S_CONVERT: begin
                    n_sh  <= n_init;
                    b_bin <= b_init;
                    rem   <= 17'd0;
                    cnt   <= 5'd16;
                    if (b_init == 14'd0) begin
                        output_1 <= 16'h9999;
                        overflow <= 1'b0;
                        div_zero <= 1'b1;
                    end
                end
                S_DIVIDE: begin
                    rem  <= rem_next;
                    n_sh <= q_next;
                    if (cnt == 5'd0) begin
                        if (q_too_big) begin
                            output_1 <= 16'h9999;
                            overflow <= 1'b1;
                            div_zero <= 1'b0;
                        end else begin
                            bin_sh <= q_next[13:0];
                            bcd    <= 16'h0000;
                            cnt    <= 5'd13;
                        end
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                S_BCD: begin
                    bcd    <= dabble_bcd;
                    bin_sh <= dabble_bin;
                    if (cnt == 5'd0) begin
                        output_1 <= dabble_bcd;
                        overflow <= 1'b0;
                        div_zero <= 1'b0;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_module.sv
// Bench for divider_module: show-ahead FIFO driver, arithmetic reference model and
// a cycle-accurate scoreboard keyed on the rd cycle of each operation.
module tb_divider_module;

    logic        clk;
    logic        reset;
    logic [15:0] entry_1;
    logic [15:0] entry_2;
    logic        empty_1;
    logic        empty_2;
    logic        full_out;
    logic        rd;
    logic        wr;
    logic [15:0] output_1;
    logic        overflow;
    logic        div_zero;
    logic        busy;

    divider_module dut (
        .clk      (clk),
        .reset    (reset),
        .entry_1  (entry_1),
        .entry_2  (entry_2),
        .empty_1  (empty_1),
        .empty_2  (empty_2),
        .full_out (full_out),
        .rd       (rd),
        .wr       (wr),
        .output_1 (output_1),
        .overflow (overflow),
        .div_zero (div_zero),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_checks = 0;
    int n_fails  = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endfunction

    // Returns {div_zero, overflow, result}
    function automatic logic [17:0] model(input logic [15:0] e1, input logic [15:0] e2);
        int a, b, n, q;
        a = e1[15:12] * 1000 + e1[11:8] * 100 + e1[7:4] * 10 + e1[3:0];
        b = e2[15:12] * 1000 + e2[11:8] * 100 + e2[7:4] * 10 + e2[3:0];
        n = (a * 10) % 131072;
        b = b % 16384;
        if (b == 0) return {2'b10, 16'h9999};
        q = n / b;
        if (q > 9999) return {2'b01, 16'h9999};
        return {2'b00, 4'(q / 1000), 4'((q / 100) % 10), 4'((q / 10) % 10), 4'(q % 10)};
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Entry: {wr_cycle[31:0], div_zero, overflow, result[15:0]}
    logic [49:0] exp_q[$];
    logic [49:0] head;
    logic [17:0] m;
    int          lat;
    int          idle_chk = -1;
    int          last_rd_cyc = 0;
    int          last_wr_cyc = 0;
    logic [15:0] last_out = 16'h0;
    logic        last_ovf = 1'b0;
    logic        last_dz  = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            chk("rd_wr_overlap", 32'(rd & wr), 32'd0);
            if (rd) begin
                chk("busy_in_read", 32'(busy), 32'd1);
                m   = model(entry_1, entry_2);
                lat = m[17] ? 2 : (m[16] ? 19 : 33);
                exp_q.push_back({32'(cycle + lat), m});
                last_rd_cyc = cycle;
            end
            if (exp_q.size() > 0 && cycle == int'(exp_q[0][49:18])) begin
                head = exp_q[0];
                chk("output_1", 32'(output_1), 32'(head[15:0]));
                chk("overflow", 32'(overflow), 32'(head[16]));
                chk("div_zero", 32'(div_zero), 32'(head[17]));
                if (!wr && full_out) begin
                    head[49:18] = head[49:18] + 32'd1;
                    exp_q[0] = head;
                end else begin
                    chk("wr_at_latency", 32'(wr), 32'd1);
                    void'(exp_q.pop_front());
                    last_wr_cyc = cycle;
                    last_out    = output_1;
                    last_ovf    = overflow;
                    last_dz     = div_zero;
                    idle_chk    = cycle + 1;
                end
            end else begin
                chk("wr_unexpected", 32'(wr), 32'd0);
            end
            if (wr) chk("wr_while_full", 32'(full_out), 32'd0);
            if (cycle == idle_chk) chk("busy_after_wr", 32'(busy), 32'd0);
        end
    end

    task automatic push_op(input logic [15:0] e1, input logic [15:0] e2);
        int n;
        bit got;
        @(posedge clk);
        #1;
        entry_1 = e1;
        entry_2 = e2;
        empty_1 = 1'b0;
        empty_2 = 1'b0;
        n   = 0;
        got = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            if (rd) got = 1;
            n++;
        end
        chk("rd_timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        empty_1 = 1'b1;
        empty_2 = 1'b1;
    endtask

    task automatic wait_done(input bit rand_bp);
        int n;
        bit seen;
        n    = 0;
        seen = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            if (wr) begin
                seen = 1;
            end else begin
                @(posedge clk);
                #1;
                if (rand_bp) full_out = ($urandom_range(0, 2) == 0);
                n++;
            end
        end
        chk("wr_timeout", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        full_out = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_last(input string name, input logic [15:0] out,
                              input logic ovf, input logic dz, input int latency);
        chk({name, "_out"}, 32'(last_out), 32'(out));
        chk({name, "_ovf"}, 32'(last_ovf), 32'(ovf));
        chk({name, "_dz"},  32'(last_dz),  32'(dz));
        chk({name, "_lat"}, 32'(last_wr_cyc - last_rd_cyc), 32'(latency));
    endtask

    initial begin
        int rd_seen;
        logic [15:0] e1, e2;
        int sel;

        reset    = 1'b1;
        entry_1  = 16'h0000;
        entry_2  = 16'h0000;
        empty_1  = 1'b1;
        empty_2  = 1'b1;
        full_out = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_output_1", 32'(output_1), 32'd0);
        chk("reset_flags", 32'({overflow, div_zero}), 32'd0);
        chk("reset_strobes", 32'({rd, wr, busy}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        chk("model_exact", 32'(model(16'h0125, 16'h0025)), 32'h00050);
        chk("model_trunc", 32'(model(16'h1000, 16'h0030)), 32'h00333);
        chk("model_ovf",   32'(model(16'h9999, 16'h0001)), 32'h19999);
        chk("model_dz",    32'(model(16'h0456, 16'h0000)), 32'h29999);

        push_op(16'h0125, 16'h0025);
        wait_done(0);
        check_last("exact", 16'h0050, 1'b0, 1'b0, 33);

        push_op(16'h1000, 16'h0030);
        wait_done(0);
        check_last("trunc", 16'h0333, 1'b0, 1'b0, 33);

        push_op(16'h9999, 16'h0001);
        wait_done(0);
        check_last("ovf", 16'h9999, 1'b1, 1'b0, 19);

        push_op(16'h0456, 16'h0000);
        wait_done(0);
        check_last("dz", 16'h9999, 1'b0, 1'b1, 2);

        // Output FIFO full for the first 5 WRITE cycles
        full_out = 1'b1;
        push_op(16'h0200, 16'h0004);
        repeat (37) @(posedge clk);
        #1;
        full_out = 1'b0;
        wait_done(0);
        check_last("bp", 16'h0500, 1'b0, 1'b0, 38);

        @(posedge clk);
        #1;
        entry_1 = 16'h0300;
        entry_2 = 16'h0010;
        empty_1 = 1'b0;
        empty_2 = 1'b1;
        rd_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (rd) rd_seen++;
        end
        chk("no_rd_when_empty", 32'(rd_seen), 32'd0);
        @(posedge clk);
        #1;
        empty_1 = 1'b1;

        // Reset during the 8th DIVIDE cycle (READ at t, DIVIDE starts at t+2)
        push_op(16'h0125, 16'h0025);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_output_1", 32'(output_1), 32'd0);
        chk("midreset_flags", 32'({overflow, div_zero}), 32'd0);
        chk("midreset_strobes", 32'({rd, wr, busy}), 32'd0);
        repeat (40) @(negedge clk);
        push_op(16'h0500, 16'h0020);
        wait_done(0);
        check_last("after_reset", 16'h0250, 1'b0, 1'b0, 33);

        for (int i = 0; i < 40; i++) begin
            e1  = to_bcd($urandom_range(0, 9999));
            sel = $urandom_range(0, 7);
            if (sel == 0)      e2 = 16'h0000;
            else if (sel == 1) e2 = to_bcd($urandom_range(1, 9));
            else               e2 = to_bcd($urandom_range(1, 9999));
            push_op(e1, e2);
            wait_done(1);
        end

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
